// File: rtl/line_window_buffer.sv
// Raster-to-column converter: turns a pixel stream into vertical 3-pixel columns
// (rows y-2, y-1, y) using two line memories, with top-edge clamping and 1-cycle latency.
module line_window_buffer #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int PIXEL_W  = 24,
  localparam int X_W     = $clog2(H_PIXELS),
  localparam int Y_W     = $clog2(V_LINES)
) (
  input  logic               daisy_clock,
  input  logic               rstbtn_n,
  input  logic               resync,
  input  logic               pixel_in_valid,
  input  logic [PIXEL_W-1:0] pixel_in,
  output logic               col_valid,
  output logic [PIXEL_W-1:0] col_top,
  output logic [PIXEL_W-1:0] col_mid,
  output logic [PIXEL_W-1:0] col_bot,
  output logic [X_W-1:0]     col_x,
  output logic [Y_W-1:0]     col_y,
  output logic               frame_start,
  output logic               line_end
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_LINES - 1);

  // lineA holds row y-1, lineB holds row y-2; deliberately not reset
  logic [PIXEL_W-1:0] line_a_mem [H_PIXELS];
  logic [PIXEL_W-1:0] line_b_mem [H_PIXELS];

  logic [X_W-1:0]     x_q, x_d, x_cur;
  logic [Y_W-1:0]     y_q, y_d, y_cur;
  logic [PIXEL_W-1:0] rd_a, rd_b;
  logic [PIXEL_W-1:0] top_s, mid_s;

  logic               col_valid_q, col_valid_d;
  logic [PIXEL_W-1:0] col_top_q, col_top_d;
  logic [PIXEL_W-1:0] col_mid_q, col_mid_d;
  logic [PIXEL_W-1:0] col_bot_q, col_bot_d;
  logic [X_W-1:0]     col_x_q, col_x_d;
  logic [Y_W-1:0]     col_y_q, col_y_d;
  logic               frame_start_q, frame_start_d;
  logic               line_end_q, line_end_d;

  // Raster position (resync takes effect in the same cycle), memory read, clamp and next state
  always_comb begin
    x_cur = resync ? {X_W{1'b0}} : x_q;
    y_cur = resync ? {Y_W{1'b0}} : y_q;
    rd_a  = line_a_mem[x_cur];
    rd_b  = line_b_mem[x_cur];

    x_d           = x_cur;
    y_d           = y_cur;
    top_s         = pixel_in;
    mid_s         = pixel_in;
    col_valid_d   = pixel_in_valid;
    col_top_d     = col_top_q;
    col_mid_d     = col_mid_q;
    col_bot_d     = col_bot_q;
    col_x_d       = col_x_q;
    col_y_d       = col_y_q;
    frame_start_d = 1'b0;
    line_end_d    = 1'b0;

    // Rows above the restart point may hold stale data, so they are only used once written
    if (y_cur == {Y_W{1'b0}}) begin
      top_s = pixel_in;
      mid_s = pixel_in;
    end else if (y_cur == Y_W'(1)) begin
      top_s = rd_a;
      mid_s = rd_a;
    end else begin
      top_s = rd_b;
      mid_s = rd_a;
    end

    if (pixel_in_valid) begin
      if (x_cur == X_LAST) begin
        x_d = {X_W{1'b0}};
        if (y_cur == Y_LAST) begin
          y_d = {Y_W{1'b0}};
        end else begin
          y_d = y_cur + Y_W'(1);
        end
      end else begin
        x_d = x_cur + X_W'(1);
        y_d = y_cur;
      end
      col_top_d     = top_s;
      col_mid_d     = mid_s;
      col_bot_d     = pixel_in;
      col_x_d       = x_cur;
      col_y_d       = y_cur;
      frame_start_d = (x_cur == {X_W{1'b0}}) && (y_cur == {Y_W{1'b0}});
      line_end_d    = (x_cur == X_LAST);
    end else begin
      x_d = x_cur;
      y_d = y_cur;
    end
  end

  // Counters and registered column outputs
  always_ff @(posedge daisy_clock or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      x_q           <= {X_W{1'b0}};
      y_q           <= {Y_W{1'b0}};
      col_valid_q   <= 1'b0;
      col_top_q     <= {PIXEL_W{1'b0}};
      col_mid_q     <= {PIXEL_W{1'b0}};
      col_bot_q     <= {PIXEL_W{1'b0}};
      col_x_q       <= {X_W{1'b0}};
      col_y_q       <= {Y_W{1'b0}};
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      col_valid_q   <= col_valid_d;
      col_top_q     <= col_top_d;
      col_mid_q     <= col_mid_d;
      col_bot_q     <= col_bot_d;
      col_x_q       <= col_x_d;
      col_y_q       <= col_y_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
    end
  end

  // Line shift: current pixel into lineA, previous lineA entry down into lineB
  always_ff @(posedge daisy_clock) begin
    if (pixel_in_valid) begin
      line_a_mem[x_cur] <= pixel_in;
      line_b_mem[x_cur] <= rd_a;
    end
  end

  assign col_valid   = col_valid_q;
  assign col_top     = col_top_q;
  assign col_mid     = col_mid_q;
  assign col_bot     = col_bot_q;
  assign col_x       = col_x_q;
  assign col_y       = col_y_q;
  assign frame_start = frame_start_q;
  assign line_end    = line_end_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer on a reduced 16x8 raster; a frame-image
// model predicts each column, a monitor pops and compares whenever col_valid is high.
module tb_line_window_buffer;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int PW = 24;
  localparam int XW = 4;
  localparam int YW = 3;

  logic          clk;
  logic          rstbtn_n;
  logic          resync;
  logic          pixel_in_valid;
  logic [PW-1:0] pixel_in;
  logic          col_valid;
  logic [PW-1:0] col_top, col_mid, col_bot;
  logic [XW-1:0] col_x;
  logic [YW-1:0] col_y;
  logic          frame_start, line_end;

  typedef struct packed {
    logic [PW-1:0] top;
    logic [PW-1:0] mid;
    logic [PW-1:0] bot;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          fs;
    logic          le;
  } col_t;

  col_t          exp_q[$];
  col_t          mon_exp, mon_act;
  int            n_cmp = 0, n_err = 0;
  int            pushed = 0, popped = 0, flushed = 0;
  int            pos = 0;
  logic [PW-1:0] img [V][H];
  logic          sampled_v;

  line_window_buffer #(.H_PIXELS(H), .V_LINES(V), .PIXEL_W(PW)) dut (
    .daisy_clock(clk), .rstbtn_n(rstbtn_n), .resync(resync),
    .pixel_in_valid(pixel_in_valid), .pixel_in(pixel_in),
    .col_valid(col_valid), .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot),
    .col_x(col_x), .col_y(col_y), .frame_start(frame_start), .line_end(line_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One input cycle; model: raster index -> (x,y), column = rows max(y-2,0), max(y-1,0), y of this frame
  task automatic step(input bit v, input bit rs, input bit pat, input logic [PW-1:0] rnd);
    int x, y;
    logic [PW-1:0] d;
    col_t c;
    @(posedge clk); #1;
    if (rs) pos = 0;
    x = pos % H;
    y = pos / H;
    d = pat ? {8'h00, 8'(y), 8'(x)} : rnd;
    resync = rs;
    pixel_in_valid = v;
    pixel_in = d;
    if (v) begin
      img[y][x] = d;
      c.top = img[(y >= 2) ? y - 2 : 0][x];
      c.mid = img[(y >= 1) ? y - 1 : 0][x];
      c.bot = d;
      c.x   = XW'(x);
      c.y   = YW'(y);
      c.fs  = (x == 0 && y == 0);
      c.le  = (x == H - 1);
      exp_q.push_back(c);
      pushed++;
      pos = (pos + 1) % (H * V);
    end
  endtask

  always @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) sampled_v <= 1'b0;
    else           sampled_v <= pixel_in_valid;
  end

  // Monitor
  always @(negedge clk) begin
    mon_act = '{top: col_top, mid: col_mid, bot: col_bot, x: col_x, y: col_y,
                fs: frame_start, le: line_end};
    if (!rstbtn_n) begin
      n_cmp++;
      if (col_valid !== 1'b0 || mon_act !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: valid=%b cols=%h required all zero", col_valid, mon_act);
      end
    end else begin
      n_cmp++;
      if (col_valid !== sampled_v) begin
        n_err++;
        $display("FAIL latency: col_valid=%b required %b", col_valid, sampled_v);
      end
      if (col_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_column: got x=%0d y=%0d with nothing expected", col_x, col_y);
        end else begin
          mon_exp = exp_q.pop_front();
          popped++;
          if (mon_act !== mon_exp) begin
            n_err++;
            $display("FAIL column: got t=%h m=%h b=%h x=%0d y=%0d fs=%b le=%b required t=%h m=%h b=%h x=%0d y=%0d fs=%b le=%b",
                     mon_act.top, mon_act.mid, mon_act.bot, mon_act.x, mon_act.y, mon_act.fs, mon_act.le,
                     mon_exp.top, mon_exp.mid, mon_exp.bot, mon_exp.x, mon_exp.y, mon_exp.fs, mon_exp.le);
          end
        end
      end else begin
        n_cmp++;
        if (frame_start !== 1'b0 || line_end !== 1'b0) begin
          n_err++;
          $display("FAIL flag_qualify: fs=%b le=%b required 0 without col_valid", frame_start, line_end);
        end
      end
    end
  end

  initial begin
    rstbtn_n = 1'b0;
    resync = 1'b0;
    pixel_in_valid = 1'b0;
    pixel_in = '0;
    repeat (3) @(posedge clk);
    #1 rstbtn_n = 1'b1;

    // contiguous pattern frames across line and frame wraps
    for (int i = 0; i < 2 * H * V + 20; i++) step(1'b1, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // random data with random gaps
    for (int i = 0; i < 3 * H * V; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, PW'($urandom));

    // resync with valid mid-frame, then resync alone
    while (pos < 3 * H + 5) step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b0, PW'($urandom));
    for (int i = 0; i < 2 * H + 7; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, PW'($urandom));
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3 * H; i++) step(1'b1, 1'b0, 1'b1, '0);

    // async reset mid-frame with a column pending
    while (pos < 4 * H + 9) step(1'b1, 1'b0, 1'b0, PW'($urandom));
    step(1'b1, 1'b0, 1'b0, PW'($urandom));
    @(posedge clk); #1;
    rstbtn_n = 1'b0;
    pixel_in_valid = 1'b0;
    resync = 1'b0;
    flushed += exp_q.size();
    exp_q.delete();
    pos = 0;
    #1;
    n_cmp++;
    if (col_valid !== 1'b0 || col_top !== '0 || col_x !== '0 || col_y !== '0) begin
      n_err++;
      $display("FAIL reset_immediate: valid=%b top=%h x=%0d y=%0d required 0", col_valid, col_top, col_x, col_y);
    end
    repeat (3) @(posedge clk);
    #1 rstbtn_n = 1'b1;
    for (int i = 0; i < 3 * H; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b1, '0);
    for (int i = 0; i < H * V; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, PW'($urandom));

    repeat (3) step(1'b0, 1'b0, 1'b0, '0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d columns never emitted, required 0", exp_q.size());
    end
    n_cmp++;
    if (popped != pushed - flushed) begin
      n_err++;
      $display("FAIL column_count: got %0d required %0d", popped, pushed - flushed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
